// File: rtl/alarm_clock_pkg.sv
// Shared types, BCD limits and helpers for the time-of-day / alarm core.
package alarm_clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  typedef struct packed {
    bcd2_t hour;
    bcd2_t min;
    bcd2_t sec;
  } hms_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ring_state_e;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  function automatic logic [23:0] pack_hms(input hms_t t);
    return {t.hour, t.min, t.sec};
  endfunction

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return '0;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

endpackage

// File: rtl/timekeeper_alarm_core_bcd_wrap_counter.sv
// Two-digit BCD counter wrapping after MAX; wrap flags the increment that rolls over.
module bcd_wrap_counter
  import alarm_clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value <= '0;
    else if (inc) value <= bcd_inc(value, MAX);
  end

  assign wrap = inc && (value == MAX);

endmodule

// File: rtl/timekeeper_alarm_core.sv
// BCD time-of-day counter with NUM_ALARMS alarms and a ring/snooze controller.
// Optional feature macro: SNOOZE_EN (builds the SNOOZE state, counter and snoozing output).
module timekeeper_alarm_core
  import alarm_clock_pkg::*;
#(
  parameter  int unsigned NUM_ALARMS = 2,
  parameter  int unsigned RING_SEC   = 60,
  parameter  int unsigned SNOOZE_SEC = 300,
  localparam int unsigned AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic                  set_time,
  input  logic                  alarm_edit,
  input  logic [AW-1:0]         alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  inc_sec,
  input  logic                  inc_min,
  input  logic                  inc_hour,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [23:0]           time_bcd,
  output logic [23:0]           alarm_bcd,
  output logic                  ringing,
  output logic                  snoozing,
  output logic [AW-1:0]         ring_id
);

  localparam logic [7:0] RING_LOAD = 8'(RING_SEC);

  logic time_tick, match_tick, set_mode;
  logic sec_inc, min_inc, hour_inc, sec_wrap, min_wrap, unused_hour_wrap;
  logic [7:0] sec_q, min_q, hour_q;
  hms_t now, nxt;
  hms_t alarm_q [NUM_ALARMS];
  logic match, ring_en;
  logic [AW-1:0] match_id;

  assign time_tick  = tick_1hz & ~set_time;
  assign match_tick = time_tick & ~alarm_edit;
  assign set_mode   = set_time & ~alarm_edit;

  // Carry chains only on run ticks; manual edits touch a single field.
  assign sec_inc  = time_tick | (set_mode & inc_sec);
  assign min_inc  = (time_tick & sec_wrap) | (set_mode & inc_min);
  assign hour_inc = (time_tick & sec_wrap & min_wrap) | (set_mode & inc_hour);

  bcd_wrap_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .value(sec_q), .wrap(sec_wrap)
  );
  bcd_wrap_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .value(min_q), .wrap(min_wrap)
  );
  bcd_wrap_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk(clk), .reset(reset), .inc(hour_inc), .value(hour_q), .wrap(unused_hour_wrap)
  );

  assign now      = '{hour: hour_q, min: min_q, sec: sec_q};
  assign time_bcd = pack_hms(now);

  always_comb begin
    nxt     = now;
    nxt.sec = bcd_inc(now.sec, SEC_MAX);
    if (now.sec == SEC_MAX) begin
      nxt.min = bcd_inc(now.min, MIN_MAX);
      if (now.min == MIN_MAX) nxt.hour = bcd_inc(now.hour, HOUR_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= '0;
    end else if (alarm_edit) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_sel == AW'(i)) begin
          if (inc_sec)  alarm_q[i].sec  <= bcd_inc(alarm_q[i].sec, SEC_MAX);
          if (inc_min)  alarm_q[i].min  <= bcd_inc(alarm_q[i].min, MIN_MAX);
          if (inc_hour) alarm_q[i].hour <= bcd_inc(alarm_q[i].hour, HOUR_MAX);
        end
      end
    end
  end

  always_comb begin
    alarm_bcd = '0;
    match     = 1'b0;
    match_id  = '0;
    ring_en   = 1'b0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (alarm_sel == AW'(i)) alarm_bcd = pack_hms(alarm_q[i]);
      if (!match && alarm_en[i] && (alarm_q[i] == nxt)) begin
        match    = 1'b1;
        match_id = AW'(i);
      end
      if (ring_id == AW'(i)) ring_en = alarm_en[i];
    end
  end

  ring_state_e   state_q, state_d;
  logic [7:0]    ring_cnt_q, ring_cnt_d;
  logic [AW-1:0] ring_id_d;
`ifdef SNOOZE_EN
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
  logic [9:0] snz_cnt_q, snz_cnt_d;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      ring_id    <= '0;
`ifdef SNOOZE_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      ring_id    <= ring_id_d;
`ifdef SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  // Exit pulses are checked before the tick so they win over the countdown.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    ring_id_d  = ring_id;
`ifdef SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (match_tick && match) begin
          state_d    = RING;
          ring_id_d  = match_id;
          ring_cnt_d = RING_LOAD;
        end
      end
      RING: begin
        if (!ring_en || dismiss) begin
          state_d = IDLE;
`ifdef SNOOZE_EN
        end else if (snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = SNOOZE_LOAD;
`endif
        end else if (time_tick) begin
          ring_cnt_d = ring_cnt_q - 8'd1;
          if (ring_cnt_d == '0) state_d = IDLE;
        end
      end
`ifdef SNOOZE_EN
      SNOOZE: begin
        if (!ring_en || dismiss) begin
          state_d = IDLE;
        end else if (time_tick) begin
          snz_cnt_d = snz_cnt_q - 10'd1;
          if (snz_cnt_d == '0) begin
            state_d    = RING;
            ring_cnt_d = RING_LOAD;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ringing = (state_q == RING);
`ifdef SNOOZE_EN
  assign snoozing = (state_q == SNOOZE);
`else
  assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_alarm_core.sv
// Directed bench for timekeeper_alarm_core; SNOOZE_EN selects which snooze expectations apply.
module tb_timekeeper_alarm_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_1hz, set_time, alarm_edit;
  logic [0:0]  alarm_sel;
  logic [1:0]  alarm_en;
  logic        inc_sec, inc_min, inc_hour, snooze, dismiss;
  logic [23:0] time_bcd, alarm_bcd;
  logic        ringing, snoozing;
  logic [0:0]  ring_id;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Stimulus bookkeeping only: lets goto_* compute how many pulses to send.
  int unsigned th = 0, tm = 0, ts = 0;
  int unsigned al_h [2] = '{0, 0};
  int unsigned al_m [2] = '{0, 0};
  int unsigned al_s [2] = '{0, 0};

  timekeeper_alarm_core #(.NUM_ALARMS(2), .RING_SEC(5), .SNOOZE_SEC(3)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_time(set_time),
    .alarm_edit(alarm_edit), .alarm_sel(alarm_sel), .alarm_en(alarm_en),
    .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
    .snooze(snooze), .dismiss(dismiss), .time_bcd(time_bcd),
    .alarm_bcd(alarm_bcd), .ringing(ringing), .snoozing(snoozing), .ring_id(ring_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    @(posedge clk); #1;
    tick_1hz = 1'b0;
    if (!set_time) begin
      ts++;
      if (ts == 60) begin
        ts = 0; tm++;
        if (tm == 60) begin tm = 0; th = (th + 1) % 24; end
      end
    end
  endtask

  // m = {hour, min, sec}
  task automatic pulse(input logic [2:0] m);
    {inc_hour, inc_min, inc_sec} = m;
    @(posedge clk); #1;
    {inc_hour, inc_min, inc_sec} = '0;
    if (alarm_edit) begin
      if (m[0]) al_s[alarm_sel] = (al_s[alarm_sel] + 1) % 60;
      if (m[1]) al_m[alarm_sel] = (al_m[alarm_sel] + 1) % 60;
      if (m[2]) al_h[alarm_sel] = (al_h[alarm_sel] + 1) % 24;
    end else if (set_time) begin
      if (m[0]) ts = (ts + 1) % 60;
      if (m[1]) tm = (tm + 1) % 60;
      if (m[2]) th = (th + 1) % 24;
    end
  endtask

  task automatic goto_time(input int unsigned h, input int unsigned m, input int unsigned s);
    set_time = 1'b1;
    repeat ((h + 24 - th) % 24) pulse(3'b100);
    repeat ((m + 60 - tm) % 60) pulse(3'b010);
    repeat ((s + 60 - ts) % 60) pulse(3'b001);
  endtask

  task automatic goto_alarm(input logic sel, input int unsigned h, input int unsigned m,
                            input int unsigned s);
    alarm_edit = 1'b1;
    alarm_sel  = sel;
    repeat ((h + 24 - al_h[sel]) % 24) pulse(3'b100);
    repeat ((m + 60 - al_m[sel]) % 60) pulse(3'b010);
    repeat ((s + 60 - al_s[sel]) % 60) pulse(3'b001);
    alarm_edit = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; tick_1hz = 0; set_time = 0; alarm_edit = 0; alarm_sel = '0;
    alarm_en = '0; inc_sec = 0; inc_min = 0; inc_hour = 0; snooze = 0; dismiss = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_time", time_bcd, 24'h000000);
    check("rst_alarm", alarm_bcd, 24'h000000);
    check("rst_ring", {23'd0, ringing}, 24'd0);
    check("rst_snz", {23'd0, snoozing}, 24'd0);
    check("rst_id", {23'd0, ring_id}, 24'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // 1: midnight rollover
    goto_time(23, 59, 59);
    check("set_235959", time_bcd, 24'h235959);
    set_time = 1'b0;
    tick();
    check("rollover", time_bcd, 24'h000000);
    check("rollover_ring", {23'd0, ringing}, 24'd0);

    // 2: set mode, field wrap without carry, ticks ignored
    goto_time(10, 20, 30);
    check("set_102030", time_bcd, 24'h102030);
    repeat (45) pulse(3'b010);
    repeat (5) tick();
    check("min_wrap_hold", time_bcd, 24'h100530);
    repeat (30) pulse(3'b001);
    check("sec_wrap_nocarry", time_bcd, 24'h100500);
    pulse(3'b111);
    check("inc_all", time_bcd, 24'h110601);

    // 3: alarm[1] match, ring timeout
    goto_alarm(1'b1, 7, 0, 0);
    alarm_edit = 1'b1; alarm_sel = 1'b1; #1;
    check("alarm1_rd", alarm_bcd, 24'h070000);
    alarm_sel = 1'b0; #1;
    check("alarm0_rd", alarm_bcd, 24'h000000);
    alarm_edit = 1'b0;
    goto_time(6, 59, 59);
    alarm_en = 2'b10;
    set_time = 1'b0;
    tick();
    check("match_time", time_bcd, 24'h070000);
    check("match_ring", {23'd0, ringing}, 24'd1);
    check("match_id", {23'd0, ring_id}, 24'd1);
    repeat (4) tick();
    check("ring_4", {23'd0, ringing}, 24'd1);
    tick();
    check("ring_timeout", {23'd0, ringing}, 24'd0);

    // 4: lowest index wins; dismiss beats snooze; clearing enable stops ring
    goto_alarm(1'b0, 12, 0, 0);
    goto_alarm(1'b1, 12, 0, 0);
    alarm_en = 2'b11;
    goto_time(11, 59, 59);
    set_time = 1'b0;
    tick();
    check("tie_ring", {23'd0, ringing}, 24'd1);
    check("tie_id", {23'd0, ring_id}, 24'd0);
    snooze = 1'b1; dismiss = 1'b1;
    @(posedge clk); #1;
    snooze = 1'b0; dismiss = 1'b0;
    check("dis_ring", {23'd0, ringing}, 24'd0);
    check("dis_snz", {23'd0, snoozing}, 24'd0);
    goto_time(11, 59, 59);
    set_time = 1'b0;
    tick();
    check("en_ring", {23'd0, ringing}, 24'd1);
    alarm_en = 2'b10;
    @(posedge clk); #1;
    check("en_clear", {23'd0, ringing}, 24'd0);

    // 5: snooze
    alarm_en = 2'b11;
    goto_time(11, 59, 59);
    set_time = 1'b0;
    tick();
    check("snz_pre", {23'd0, ringing}, 24'd1);
    snooze = 1'b1;
    @(posedge clk); #1;
    snooze = 1'b0;
`ifdef SNOOZE_EN
    check("snz_on", {23'd0, snoozing}, 24'd1);
    check("snz_ringoff", {23'd0, ringing}, 24'd0);
    repeat (2) tick();
    check("snz_hold", {23'd0, snoozing}, 24'd1);
    tick();
    check("snz_rering", {23'd0, ringing}, 24'd1);
    check("snz_id", {23'd0, ring_id}, 24'd0);
    check("snz_off", {23'd0, snoozing}, 24'd0);
`else
    check("nosnz_ring", {23'd0, ringing}, 24'd1);
    check("nosnz_snz", {23'd0, snoozing}, 24'd0);
`endif
    dismiss = 1'b1;
    @(posedge clk); #1;
    dismiss = 1'b0;
    check("snz_dismiss", {23'd0, ringing}, 24'd0);

    // 6: asynchronous reset mid-ring
    goto_alarm(1'b1, 3, 4, 5);
    alarm_en = 2'b10;
    goto_time(3, 4, 4);
    set_time = 1'b0;
    alarm_sel = 1'b1;
    tick();
    check("pre_rst_time", time_bcd, 24'h030405);
    check("pre_rst_ring", {23'd0, ringing}, 24'd1);
    check("pre_rst_id", {23'd0, ring_id}, 24'd1);
    #3 reset = 1'b0;
    #1;
    check("arst_time", time_bcd, 24'h000000);
    check("arst_alarm", alarm_bcd, 24'h000000);
    check("arst_ring", {23'd0, ringing}, 24'd0);
    check("arst_id", {23'd0, ring_id}, 24'd0);
    th = 0; tm = 0; ts = 0;
    al_h = '{0, 0}; al_m = '{0, 0}; al_s = '{0, 0};
    @(negedge clk) reset = 1'b1;
    tick();
    check("post_rst_time", time_bcd, 24'h000001);
    check("post_rst_ring", {23'd0, ringing}, 24'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
